// File: rtl/mcp41hv51_spi_target.sv
// -----------------------------------------------------------------------------
// mcp41hv51_spi_target
// SPI mode-0 target that emulates the volatile register interface of an
// MCP41HV51 digipot. It holds the wiper and TCON registers and decodes the
// write, read, increment and decrement commands. It drives MISO during reads
// and latches a sticky error when a command is malformed. Every SPI pin is
// oversampled on clk, so no logic runs on SCK.
//
// Ports
//   clk          system clock, at least 8x the SCK frequency
//   reset        asynchronous, active-high; returns all state to reset values
//   spi_cs_n     chip select, active low
//   spi_sck      SPI clock (CPOL=0, CPHA=0)
//   spi_mosi     serial data in, MSB first
//   spi_miso     serial data out (idles high)
//   wiper_value  current wiper register
//   tcon_value   current TCON register
//   wiper_update one-cycle pulse whenever wiper_value changes
//   cmd_err      sticky malformed-command flag, cleared only by reset
// -----------------------------------------------------------------------------
module mcp41hv51_spi_target #(
    parameter logic [7:0] DEFAULT_WIPER = 8'd128,
    parameter logic [7:0] DEFAULT_TCON  = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_cs_n,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] wiper_value,
    output logic [7:0] tcon_value,
    output logic       wiper_update,
    output logic       cmd_err
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [3:0] ADDR_WIPER = 4'h0;
    localparam logic [3:0] ADDR_TCON  = 4'h4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_DEC   = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Pin synchronisers: two flops per pin, plus a third stage for edge detection.
    // The cs_n chain resets low. A frame that is still in flight when reset is
    // released then shows no falling edge, and CMD is entered only after cs_n
    // has gone high and come back low.
    logic [2:0] cs_pipe;
    logic [2:0] sck_pipe;
    logic [1:0] mosi_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_pipe   <= '0;
            sck_pipe  <= '0;
            mosi_pipe <= '0;
        end else begin
            cs_pipe   <= {cs_pipe[1:0], spi_cs_n};
            sck_pipe  <= {sck_pipe[1:0], spi_sck};
            mosi_pipe <= {mosi_pipe[0], spi_mosi};
        end
    end

    logic cs_fall;
    logic cs_rise;
    logic sck_rise;
    logic sck_fall;
    logic mosi_bit;

    assign cs_fall  =  cs_pipe[2]  & ~cs_pipe[1];
    assign cs_rise  = ~cs_pipe[2]  &  cs_pipe[1];
    assign sck_rise = ~sck_pipe[2] &  sck_pipe[1];
    assign sck_fall =  sck_pipe[2] & ~sck_pipe[1];
    assign mosi_bit =  mosi_pipe[1];

    // Datapath registers
    logic [CNT_W-1:0]  bit_cnt;
    logic [BYTE_W-2:0] shift_in;
    logic [BYTE_W-1:0] tx_shift;
    logic [3:0]        addr_q;
    logic              rd_mode;

    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic [BYTE_W-2:0] shift_in_nxt;
    logic [BYTE_W-1:0] tx_shift_nxt;
    logic [3:0]        addr_nxt;
    logic              rd_mode_nxt;
    logic              miso_nxt;
    logic [7:0]        wiper_nxt;
    logic [7:0]        tcon_nxt;
    logic              update_nxt;
    logic              err_nxt;

    // The byte as it will stand once the bit sampled on this sck_rise is added
    logic [BYTE_W-1:0] rx_byte;
    logic [3:0]        rx_addr;
    logic [1:0]        rx_op;
    logic              last_bit;
    logic              cmd_ok;

    assign rx_byte  = {shift_in, mosi_bit};
    assign rx_addr  = rx_byte[7:4];
    assign rx_op    = rx_byte[3:2];
    assign last_bit = (bit_cnt == CNT_W'(BYTE_W - 1));
    // The wiper accepts every opcode. TCON accepts only write and read.
    assign cmd_ok   = (rx_addr == ADDR_WIPER) ||
                      ((rx_addr == ADDR_TCON) && ((rx_op == OP_WRITE) || (rx_op == OP_READ)));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_nxt = CMD;
                    end
                end
                CMD: begin
                    if (sck_rise && last_bit) begin
                        if (!cmd_ok) begin
                            state_nxt = HALT;
                        end else if ((rx_op == OP_WRITE) || (rx_op == OP_READ)) begin
                            state_nxt = DATA;
                        end
                    end
                end
                DATA: begin
                    if (sck_rise && last_bit) begin
                        state_nxt = CMD;
                    end
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output and datapath next-values
    always_comb begin
        bit_cnt_nxt  = bit_cnt;
        shift_in_nxt = shift_in;
        tx_shift_nxt = tx_shift;
        addr_nxt     = addr_q;
        rd_mode_nxt  = rd_mode;
        miso_nxt     = spi_miso;
        wiper_nxt    = wiper_value;
        tcon_nxt     = tcon_value;
        update_nxt   = 1'b0;
        err_nxt      = cmd_err;

        if (cs_rise) begin
            // A partial byte is dropped without any side effect
            miso_nxt = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    miso_nxt = 1'b1;
                    if (cs_fall) begin
                        bit_cnt_nxt  = '0;
                        shift_in_nxt = '0;
                    end
                end
                CMD: begin
                    if (sck_fall) begin
                        miso_nxt = 1'b1;
                    end
                    if (sck_rise) begin
                        shift_in_nxt = rx_byte[BYTE_W-2:0];
                        bit_cnt_nxt  = bit_cnt + CNT_W'(1);   // wraps to 0 after the 8th bit
                        if (last_bit) begin
                            addr_nxt    = rx_addr;
                            rd_mode_nxt = (rx_op == OP_READ);
                            if (!cmd_ok) begin
                                err_nxt = 1'b1;
                            end else if (rx_op == OP_READ) begin
                                tx_shift_nxt = (rx_addr == ADDR_TCON) ? tcon_value : wiper_value;
                            end else if (rx_op == OP_INC) begin
                                if (wiper_value != 8'hFF) begin
                                    wiper_nxt  = wiper_value + 8'd1;
                                    update_nxt = 1'b1;
                                end
                            end else if (rx_op == OP_DEC) begin
                                if (wiper_value != 8'h00) begin
                                    wiper_nxt  = wiper_value - 8'd1;
                                    update_nxt = 1'b1;
                                end
                            end
                        end
                    end
                end
                DATA: begin
                    // The first falling edge here is the 8th edge of the command byte.
                    // The read MSB therefore appears before the first data-byte rise.
                    if (sck_fall) begin
                        if (rd_mode) begin
                            miso_nxt     = tx_shift[BYTE_W-1];
                            tx_shift_nxt = {tx_shift[BYTE_W-2:0], 1'b0};
                        end else begin
                            miso_nxt = 1'b1;
                        end
                    end
                    if (sck_rise) begin
                        shift_in_nxt = rx_byte[BYTE_W-2:0];
                        bit_cnt_nxt  = bit_cnt + CNT_W'(1);
                        if (last_bit && !rd_mode) begin
                            if (addr_q == ADDR_WIPER) begin
                                wiper_nxt  = rx_byte;
                                update_nxt = (rx_byte != wiper_value);
                            end else begin
                                tcon_nxt = rx_byte;
                            end
                        end
                    end
                end
                HALT: begin
                    miso_nxt = 1'b1;
                end
                default: begin
                    miso_nxt = 1'b1;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt      <= '0;
            shift_in     <= '0;
            tx_shift     <= '0;
            addr_q       <= '0;
            rd_mode      <= 1'b0;
            spi_miso     <= 1'b1;
            wiper_value  <= DEFAULT_WIPER;
            tcon_value   <= DEFAULT_TCON;
            wiper_update <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            bit_cnt      <= bit_cnt_nxt;
            shift_in     <= shift_in_nxt;
            tx_shift     <= tx_shift_nxt;
            addr_q       <= addr_nxt;
            rd_mode      <= rd_mode_nxt;
            spi_miso     <= miso_nxt;
            wiper_value  <= wiper_nxt;
            tcon_value   <= tcon_nxt;
            wiper_update <= update_nxt;
            cmd_err      <= err_nxt;
        end
    end

endmodule
